// File: rtl/reg_block_loader.sv
// -----------------------------------------------------------------------------
// reg_block_loader
//
// Purpose:
//   Block-load sequencer. It copies `count` consecutive words from a
//   synchronous-read data RAM into consecutive register-file entries. This is
//   the RAM->register path. Each word takes three cycles:
//     ISSUE   - ram_addr presents the word address. The RAM samples it at the
//               end of this cycle.
//     CAPTURE - douta is valid. It is latched into W_Data, and the register
//               index is latched into W_Addr.
//     WRITE   - Write_reg is high. The register file captures at the end of
//               this cycle.
//   A load of N>0 words ends with a one-cycle DONE state, which occurs
//   3N+1 cycles after the start edge.
//
// Ports:
//   Clk        in   1       rising-edge clock
//   Reset      in   1       synchronous, active-low reset
//   start      in   1       load request; only honoured in IDLE
//   base_addr  in   ADDR_W  first RAM word address (latched on accept)
//   first_reg  in   REG_W   first destination register (latched on accept)
//   count      in   ADDR_W  number of words to copy (latched on accept)
//   ram_addr   out  ADDR_W  registered RAM word address
//   ram_wea    out  1       RAM write enable; always 0
//   douta      in   DATA_W  RAM read data, one cycle after the address
//   W_Addr     out  REG_W   registered register-file write index
//   W_Data     out  DATA_W  registered register-file write data
//   Write_reg  out  1       registered register-file write strobe
//   busy       out  1       high while a load is in progress (not in DONE)
//   done       out  1       one-cycle completion pulse
// -----------------------------------------------------------------------------
module reg_block_loader #(
  parameter int ADDR_W = 6,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [REG_W-1:0]  first_reg,
  input  logic [ADDR_W-1:0] count,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wea,
  input  logic [DATA_W-1:0] douta,
  output logic [REG_W-1:0]  W_Addr,
  output logic [DATA_W-1:0] W_Data,
  output logic              Write_reg,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [REG_W-1:0]  reg_q, reg_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [REG_W-1:0]  w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              write_q, write_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // State and output registers
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      reg_q      <= '0;
      ram_addr_q <= '0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      reg_q      <= reg_d;
      ram_addr_q <= ram_addr_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      write_q    <= write_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (count != '0) ? S_ISSUE : S_DONE;
      end
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_WRITE;
      // rem_q still counts the word currently being written
      S_WRITE:   state_d = (rem_q != ADDR_W'(1)) ? S_ISSUE : S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values. All outputs are registered, so they
  // are computed from the state being entered.
  always_comb begin
    addr_d     = addr_q;
    rem_d      = rem_q;
    reg_d      = reg_q;
    ram_addr_d = ram_addr_q;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    write_d    = 1'b0;
    busy_d     = (state_d == S_ISSUE) || (state_d == S_CAPTURE) ||
                 (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = base_addr;
          reg_d  = first_reg;
          rem_d  = count;
          // A zero-length load leaves ram_addr untouched.
          if (count != '0) ram_addr_d = base_addr;
        end
      end
      S_CAPTURE: begin
        w_data_d = douta;
        w_addr_d = reg_q;
        write_d  = 1'b1;
      end
      S_WRITE: begin
        // Both indices wrap naturally at their widths.
        addr_d = addr_q + ADDR_W'(1);
        reg_d  = reg_q + REG_W'(1);
        rem_d  = rem_q - ADDR_W'(1);
        if (state_d == S_ISSUE) ram_addr_d = addr_q + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  assign ram_addr  = ram_addr_q;
  assign ram_wea   = 1'b0;
  assign W_Addr    = w_addr_q;
  assign W_Data    = w_data_q;
  assign Write_reg = write_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
